// File: rtl/tb_mem_copier_pkg.sv
// Shared types for the memory copier and the test memory it drives.
`default_nettype none

package tb_mem_copier_pkg;

    typedef enum logic {
        cpu_data_acc_sz_8  = 1'b0,
        cpu_data_acc_sz_16 = 1'b1
    } cpu_data_acc_sz_e;

    typedef struct packed {
        logic [15:0]      read_addr_in;
        cpu_data_acc_sz_e read_data_acc_sz;
        logic [15:0]      write_addr_in;
        logic [15:0]      write_data_in;
        cpu_data_acc_sz_e write_data_acc_sz;
        logic             write_data_we;
    } tb_mem_inputs;

endpackage

`default_nettype wire

// File: rtl/tb_mem_copier.sv
// Memory copy / fill engine: moves byte_len bytes using 16-bit accesses where possible.
// Revision: 1.0
`default_nettype none

module tb_mem_copier
    import tb_mem_copier_pkg::*;
#(
    parameter bit WIDE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [15:0]  src_addr,
    input  logic [15:0]  dst_addr,
    input  logic [15:0]  byte_len,
    input  logic [15:0]  fill_val,
    output tb_mem_inputs mem_inputs,
    input  logic [15:0]  mem_read_data,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bytes_done,
    output logic [15:0]  checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic        mode_q, mode_d;
    logic [15:0] fill_q, fill_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] bytes_q, bytes_d;
    logic [15:0] csum_q, csum_d;

    logic             w_wide;
    logic [15:0]      w_step;
    cpu_data_acc_sz_e w_acc;
    logic [15:0]      w_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            hold_q  <= '0;
            bytes_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
            bytes_q <= bytes_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        mode_d     = mode_q;
        fill_d     = fill_q;
        hold_d     = hold_q;
        bytes_d    = bytes_q;
        csum_d     = csum_q;
        mem_inputs = '0;

        // Step size follows the remaining count, so a trailing odd byte uses an 8-bit access.
        w_wide  = WIDE_EN && (rem_q >= 16'd2);
        w_step  = w_wide ? 16'd2 : 16'd1;
        w_acc   = w_wide ? cpu_data_acc_sz_16 : cpu_data_acc_sz_8;
        w_wdata = mode_q ? fill_q : hold_q;
        if (!w_wide) begin
            w_wdata[15:8] = 8'h00;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = byte_len;
                    mode_d  = mode;
                    fill_d  = fill_val;
                    bytes_d = '0;
                    csum_d  = '0;
                    if (byte_len == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = mode ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                mem_inputs.read_addr_in     = src_q;
                mem_inputs.read_data_acc_sz = w_acc;
                hold_d                      = mem_read_data;
                state_d                     = S_WRITE;
            end
            S_WRITE: begin
                mem_inputs.write_addr_in     = dst_q;
                mem_inputs.write_data_in     = w_wdata;
                mem_inputs.write_data_acc_sz = w_acc;
                mem_inputs.write_data_we     = 1'b1;
                src_d   = src_q + w_step;
                dst_d   = dst_q + w_step;
                rem_d   = rem_q - w_step;
                bytes_d = bytes_q + w_step;
                csum_d  = csum_q + {8'h00, w_wdata[7:0]} + {8'h00, w_wdata[15:8]};
                if (rem_q == w_step) begin
                    state_d = S_DONE;
                end else begin
                    state_d = mode_q ? S_WRITE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign bytes_done = bytes_q;
    assign checksum   = csum_q;

endmodule

`default_nettype wire
